timer_ctrl: RTL

- Register-programmed control and interrupt front end for the digitalTimer countdown block.
- Upstream, it loads the timer: drives timer_set_val and pulses set_timer.
- Downstream, it consumes timer_is_high and turns expiries into a sticky pending flag, a maskable interrupt and an expiry counter.
- Supports one-shot and periodic (auto-reload) modes. Software reaches it through a simple single-cycle register port.

---
 rtl/timer_ctrl_pkg.sv | 31 +++
 rtl/timer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for timer_ctrl: FSM states, register offsets and field bit positions.
package timer_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  // Load/expiry sequencing of the attached digitalTimer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_GUARD = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Register byte offsets
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_EXPCNT = 4'hC;

  // CTRL fields
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  // STATUS fields
  localparam int unsigned STAT_PENDING    = 0;
  localparam int unsigned STAT_MISS_CLR   = 1;
  localparam int unsigned STAT_MISSED_LSB = 8;

endpackage

// File: rtl/timer_ctrl.sv
// Register-programmed control and interrupt front end for the digitalTimer block.
// Loads the timer (timer_set_val + set_timer strobe), turns timer_is_high expiries
// into a sticky PENDING flag, a maskable irq, a saturating MISSED count and a
// wrapping EXPCNT, with one-shot and periodic (auto-reload) modes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/write/addr/wdata   single-cycle register access (always accepted)
//   resp_valid, resp_rdata   registered read response, 1 cycle after a read
//   timer_set_val, set_timer load value and one-cycle load strobe to digitalTimer
//   timer_is_high            digitalTimer expired flag
//   irq                      registered interrupt request (PENDING & IRQ_EN)
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned MISS_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] timer_set_val,
  output logic              set_timer,
  input  logic              timer_is_high,
  output logic              irq
);

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic                periodic_q, periodic_d;
  logic                irq_en_q, irq_en_d;
  logic [DATA_W-1:0]   period_q, period_d;
  logic                pend_q, pend_d;
  logic [MISS_W-1:0]   missed_q, missed_d;
  logic [CNT_W-1:0]    expcnt_q, expcnt_d;
  logic                set_timer_q, set_timer_d;
  logic [DATA_W-1:0]   set_val_q, set_val_d;
  logic                irq_q, irq_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic                wr, rd;
  logic                ctrl_wr, period_wr, status_wr;
  logic                pend_clr, miss_clr, miss_inc;
  logic                expiry;
  logic [DATA_W-1:0]   rdata_mux;

  // Access decode
  assign wr        = req_valid & req_write;
  assign rd        = req_valid & ~req_write;
  assign ctrl_wr   = wr & (req_addr == ADDR_CTRL);
  assign period_wr = wr & (req_addr == ADDR_PERIOD);
  assign status_wr = wr & (req_addr == ADDR_STATUS);
  assign pend_clr  = status_wr & req_wdata[STAT_PENDING];
  assign miss_clr  = status_wr & req_wdata[STAT_MISS_CLR];

  // A disabling CTRL write in the same cycle discards the expiry
  assign expiry = (state_q == ST_RUN) & timer_is_high & ~(ctrl_wr & ~req_wdata[CTRL_EN]);

  // A PENDING clear racing an expiry behaves as clear-then-set: no miss is counted
  assign miss_inc = expiry & pend_q & ~pend_clr;

  // Read mux over pre-update register state
  always_comb begin
    rdata_mux = '0;
    case (req_addr)
      ADDR_CTRL: begin
        rdata_mux[CTRL_EN]       = en_q;
        rdata_mux[CTRL_PERIODIC] = periodic_q;
        rdata_mux[CTRL_IRQ_EN]   = irq_en_q;
      end
      ADDR_PERIOD: rdata_mux = period_q;
      ADDR_STATUS: begin
        rdata_mux[STAT_PENDING]                   = pend_q;
        rdata_mux[STAT_MISSED_LSB +: MISS_W]      = missed_q;
      end
      ADDR_EXPCNT: rdata_mux = DATA_W'(expcnt_q);
      default:     rdata_mux = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    periodic_d   = periodic_q;
    irq_en_d     = irq_en_q;
    period_d     = period_q;
    pend_d       = pend_q;
    missed_d     = missed_q;
    expcnt_d     = expcnt_q;
    set_val_d    = set_val_q;
    set_timer_d  = 1'b0;
    resp_valid_d = rd;
    resp_rdata_d = resp_rdata_q;
    irq_d        = 1'b0;

    if (rd) begin
      resp_rdata_d = rdata_mux;
    end

    if (period_wr) begin
      period_d = req_wdata;
    end

    // Sequencing; GUARD ignores the stale high left over from the previous expiry
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_ARM:   state_d = ST_GUARD;
      ST_GUARD: state_d = ST_RUN;
      ST_RUN: begin
        if (expiry) begin
          state_d = periodic_q ? ST_ARM : ST_IDLE;
          if (!periodic_q) begin
            en_d = 1'b0;
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // Software CTRL write overrides the sequencer (restart or stop)
    if (ctrl_wr) begin
      en_d       = req_wdata[CTRL_EN];
      periodic_d = req_wdata[CTRL_PERIODIC];
      irq_en_d   = req_wdata[CTRL_IRQ_EN];
      state_d    = req_wdata[CTRL_EN] ? ST_ARM : ST_IDLE;
    end

    if (expiry) begin
      expcnt_d = expcnt_q + CNT_W'(1);
    end

    pend_d = expiry | (pend_q & ~pend_clr);

    if (miss_clr) begin
      missed_d = '0;
    end
    if (miss_inc && (missed_d != {MISS_W{1'b1}})) begin
      missed_d = missed_d + MISS_W'(1);
    end

    // Load strobe is high for the ARM cycle; value is PERIOD as seen in ARM
    if (state_d == ST_ARM) begin
      set_timer_d = 1'b1;
      set_val_d   = period_d;
    end

    irq_d = pend_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      periodic_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      period_q     <= '0;
      pend_q       <= 1'b0;
      missed_q     <= '0;
      expcnt_q     <= '0;
      set_timer_q  <= 1'b0;
      set_val_q    <= '0;
      irq_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      periodic_q   <= periodic_d;
      irq_en_q     <= irq_en_d;
      period_q     <= period_d;
      pend_q       <= pend_d;
      missed_q     <= missed_d;
      expcnt_q     <= expcnt_d;
      set_timer_q  <= set_timer_d;
      set_val_q    <= set_val_d;
      irq_q        <= irq_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign timer_set_val = set_val_q;
  assign set_timer     = set_timer_q;
  assign irq           = irq_q;

endmodule
